// File: rtl/loop_address_unit_if.sv
// Command/response, configuration and status bundle of the loop address unit.
// Parameters must match those of the loop_address_unit instance it is bound to.
interface loop_address_unit_if #(
    parameter int LOOP_DEPTH = 8,
    parameter int LOOP_SLOTS = 8,
    parameter int NUM_CHAN   = 4,
    parameter int ADDR_W     = 18,
    parameter int CNT_W      = 16
);
    localparam int SLOT_W  = (LOOP_SLOTS > 1) ? $clog2(LOOP_SLOTS) : 1;
    localparam int CHAN_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int DEPTH_W = $clog2(LOOP_DEPTH + 1);

    logic                       cfg_we;
    logic [1:0]                 cfg_kind;
    logic [SLOT_W-1:0]          cfg_slot;
    logic [CHAN_W-1:0]          cfg_chan;
    logic [ADDR_W-1:0]          cfg_data;

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_is_start;
    logic [SLOT_W-1:0]          cmd_slot;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic                       rsp_jump;
    logic                       rsp_done;
    logic                       rsp_error;

    logic [NUM_CHAN*ADDR_W-1:0] addr;
    logic [DEPTH_W-1:0]         depth;
    logic [CNT_W-1:0]           loop_var;

    modport master (
        output cfg_we, cfg_kind, cfg_slot, cfg_chan, cfg_data,
        output cmd_valid, cmd_is_start, cmd_slot, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_jump, rsp_done, rsp_error,
        input  addr, depth, loop_var
    );

    modport slave (
        input  cfg_we, cfg_kind, cfg_slot, cfg_chan, cfg_data,
        input  cmd_valid, cmd_is_start, cmd_slot, rsp_ready,
        output cmd_ready, rsp_valid, rsp_jump, rsp_done, rsp_error,
        output addr, depth, loop_var
    );
endinterface

// File: rtl/loop_address_unit.sv
// Hardware loop-nest sequencer with incremental per-channel address generation.
// A loop stack holds slot, trip counter and the channel addresses at loop entry;
// back-edges add the slot stride, exits restore the saved addresses.
module loop_address_unit #(
    parameter int LOOP_DEPTH = 8,
    parameter int LOOP_SLOTS = 8,
    parameter int NUM_CHAN   = 4,
    parameter int ADDR_W     = 18,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    loop_address_unit_if.slave bus
);
    localparam int SLOT_W  = (LOOP_SLOTS > 1) ? $clog2(LOOP_SLOTS) : 1;
    localparam int DEPTH_W = $clog2(LOOP_DEPTH + 1);
    localparam int STK_W   = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

    typedef enum logic {IDLE, RESP} state_t;
    state_t state_q, state_d;

    logic [CNT_W-1:0]   trip_q     [LOOP_SLOTS];
    logic [ADDR_W-1:0]  stride_q   [LOOP_SLOTS][NUM_CHAN];
    logic [ADDR_W-1:0]  addr_q     [NUM_CHAN];
    logic [SLOT_W-1:0]  stk_slot_q [LOOP_DEPTH];
    logic [CNT_W-1:0]   stk_cnt_q  [LOOP_DEPTH];
    logic [ADDR_W-1:0]  stk_sav_q  [LOOP_DEPTH][NUM_CHAN];
    logic [DEPTH_W-1:0] depth_q;
    logic               jump_q, done_q, err_q;

    logic               fire, cfg_ok, stk_full, stk_empty, take_back;
    logic [DEPTH_W-1:0] top_w;
    logic [STK_W-1:0]   top_idx, push_idx;
    logic [SLOT_W-1:0]  top_slot;
    logic [CNT_W-1:0]   trip_eff;

    assign bus.cmd_ready = (state_q == IDLE) && reset;
    assign fire          = bus.cmd_valid && bus.cmd_ready;

    // Stack pointers: top entry sits one below depth; a push lands at depth.
    assign stk_full  = (depth_q == DEPTH_W'(LOOP_DEPTH));
    assign stk_empty = (depth_q == '0);
    assign top_w     = depth_q - DEPTH_W'(1);
    assign top_idx   = top_w[STK_W-1:0];
    assign push_idx  = depth_q[STK_W-1:0];
    assign top_slot  = stk_slot_q[top_idx];

    // A zero trip count behaves like a single pass.
    assign trip_eff  = (trip_q[top_slot] == '0) ? CNT_W'(1) : trip_q[top_slot];
    assign take_back = ({1'b0, stk_cnt_q[top_idx]} + (CNT_W+1)'(1)) < {1'b0, trip_eff};

    // Tables only change with an empty, idle stack so live descriptors never move.
    assign cfg_ok = bus.cfg_we && stk_empty && (state_q == IDLE) && !fire;

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_jump  = jump_q;
    assign bus.rsp_done  = done_q;
    assign bus.rsp_error = err_q;
    assign bus.depth     = depth_q;
    assign bus.loop_var  = stk_empty ? '0 : stk_cnt_q[top_idx];

    for (genvar g = 0; g < NUM_CHAN; g++) begin : g_addr
        assign bus.addr[g*ADDR_W +: ADDR_W] = addr_q[g];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: one command in, one response out, then back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fire)          state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Datapath: config tables, loop stack, channel addresses and response flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            depth_q <= '0;
            jump_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int s = 0; s < LOOP_SLOTS; s++) begin
                trip_q[s] <= '0;
                for (int c = 0; c < NUM_CHAN; c++) stride_q[s][c] <= '0;
            end
            for (int c = 0; c < NUM_CHAN; c++) addr_q[c] <= '0;
            for (int d = 0; d < LOOP_DEPTH; d++) begin
                stk_slot_q[d] <= '0;
                stk_cnt_q[d]  <= '0;
                for (int c = 0; c < NUM_CHAN; c++) stk_sav_q[d][c] <= '0;
            end
        end else begin
            if (state_q == RESP && bus.rsp_ready) begin
                jump_q <= 1'b0;
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (fire) begin
                jump_q <= 1'b0;
                done_q <= 1'b0;
                err_q  <= 1'b0;
                if (bus.cmd_is_start) begin
                    if (stk_full) begin
                        err_q <= 1'b1;
                    end else begin
                        stk_slot_q[push_idx] <= bus.cmd_slot;
                        stk_cnt_q[push_idx]  <= '0;
                        for (int c = 0; c < NUM_CHAN; c++) stk_sav_q[push_idx][c] <= addr_q[c];
                        depth_q <= depth_q + DEPTH_W'(1);
                    end
                end else if (stk_empty) begin
                    err_q <= 1'b1;
                end else if (take_back) begin
                    stk_cnt_q[top_idx] <= stk_cnt_q[top_idx] + CNT_W'(1);
                    for (int c = 0; c < NUM_CHAN; c++) addr_q[c] <= addr_q[c] + stride_q[top_slot][c];
                    jump_q <= 1'b1;
                end else begin
                    for (int c = 0; c < NUM_CHAN; c++) addr_q[c] <= stk_sav_q[top_idx][c];
                    depth_q <= top_w;
                    done_q  <= 1'b1;
                end
            end else if (cfg_ok) begin
                case (bus.cfg_kind)
                    2'd0:    trip_q[bus.cfg_slot]               <= bus.cfg_data[CNT_W-1:0];
                    2'd1:    stride_q[bus.cfg_slot][bus.cfg_chan] <= bus.cfg_data;
                    2'd2:    addr_q[bus.cfg_chan]                <= bus.cfg_data;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_loop_address_unit.sv
// Directed bench for loop_address_unit: expected responses are queued as each
// command is driven and popped when the response appears.
module tb_loop_address_unit;
    localparam int LOOP_DEPTH = 8;
    localparam int LOOP_SLOTS = 8;
    localparam int NUM_CHAN   = 4;
    localparam int ADDR_W     = 18;
    localparam int CNT_W      = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    loop_address_unit_if #(.LOOP_DEPTH(LOOP_DEPTH), .LOOP_SLOTS(LOOP_SLOTS),
        .NUM_CHAN(NUM_CHAN), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    loop_address_unit #(.LOOP_DEPTH(LOOP_DEPTH), .LOOP_SLOTS(LOOP_SLOTS),
        .NUM_CHAN(NUM_CHAN), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        string tag;
        logic  j, d, e;
        int    ch;
        int    a;
        int    dep;
        int    lv;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t E(input string tag, input logic j, input logic d, input logic e,
                               input int ch, input int a, input int dep, input int lv);
        exp_t x;
        x.tag = tag; x.j = j; x.d = d; x.e = e; x.ch = ch; x.a = a; x.dep = dep; x.lv = lv;
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ch_addr(input int ch);
        logic [NUM_CHAN*ADDR_W-1:0] v;
        v = bus.addr;
        return 32'(v[ch*ADDR_W +: ADDR_W]);
    endfunction

    task automatic cfg(input int kind, input int slot, input int chan, input int data);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_kind = 2'(kind);
        bus.cfg_slot = 3'(slot);
        bus.cfg_chan = 2'(chan);
        bus.cfg_data = ADDR_W'(data);
        @(negedge clk);
        bus.cfg_we   = 1'b0;
    endtask

    // Issue one command; optionally stall the response, optionally leave it unconsumed.
    task automatic cmd(input logic st, input int slot, input exp_t e, input int hold, input bit consume);
        exp_t x;
        int   n;
        sb.push_back(e);
        @(negedge clk);
        bus.cmd_valid    = 1'b1;
        bus.cmd_is_start = st;
        bus.cmd_slot     = 3'(slot);
        bus.rsp_ready    = 1'b0;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
        chk({e.tag, "/cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        x = sb.pop_front();
        chk({x.tag, "/rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({x.tag, "/jump"},  32'(bus.rsp_jump),  32'(x.j));
        chk({x.tag, "/done"},  32'(bus.rsp_done),  32'(x.d));
        chk({x.tag, "/error"}, 32'(bus.rsp_error), 32'(x.e));
        chk({x.tag, "/addr"},  ch_addr(x.ch),      32'(x.a));
        chk({x.tag, "/depth"}, 32'(bus.depth),     32'(x.dep));
        chk({x.tag, "/loop_var"}, 32'(bus.loop_var), 32'(x.lv));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({x.tag, "/hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({x.tag, "/hold_flags"}, {29'd0, bus.rsp_jump, bus.rsp_done, bus.rsp_error},
                {29'd0, x.j, x.d, x.e});
            chk({x.tag, "/hold_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
        end
        if (consume) begin
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0;
            chk({x.tag, "/rsp_cleared"}, 32'(bus.rsp_valid), 32'd0);
            chk({x.tag, "/ready_again"}, 32'(bus.cmd_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_kind = '0; bus.cfg_slot = '0; bus.cfg_chan = '0; bus.cfg_data = '0;
        bus.cmd_valid = 1'b0; bus.cmd_is_start = 1'b0; bus.cmd_slot = '0; bus.rsp_ready = 1'b0;

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst/depth",     32'(bus.depth),     32'd0);
        chk("rst/addr_lo",   bus.addr[31:0],     32'd0);
        chk("rst/addr_hi",   32'(bus.addr[NUM_CHAN*ADDR_W-1:32]), 32'd0);
        chk("rst/loop_var",  32'(bus.loop_var),  32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst/ready_after", 32'(bus.cmd_ready), 32'd1);

        // Single loop: trip 3, stride ch0 = 2
        cfg(0, 0, 0, 3);
        cfg(1, 0, 0, 2);
        cfg(2, 0, 0, 0);
        cmd(1, 0, E("s1/start", 0, 0, 0, 0, 0, 1, 0), 0, 1);
        cmd(0, 0, E("s1/end1",  1, 0, 0, 0, 2, 1, 1), 0, 1);
        cmd(0, 0, E("s1/end2",  1, 0, 0, 0, 4, 1, 2), 0, 1);
        cmd(0, 0, E("s1/end3",  0, 1, 0, 0, 0, 0, 0), 0, 1);

        // Nested: outer slot1 trip 2 stride ch1 16; inner slot0 trip 2 stride ch1 1
        cfg(0, 1, 0, 2);
        cfg(1, 1, 1, 16);
        cfg(0, 0, 0, 2);
        cfg(1, 0, 1, 1);
        cmd(1, 1, E("n/outer",   0, 0, 0, 1, 0,  1, 0), 0, 1);
        cmd(1, 0, E("n/inner1",  0, 0, 0, 1, 0,  2, 0), 0, 1);
        cmd(0, 0, E("n/in1_j",   1, 0, 0, 1, 1,  2, 1), 0, 1);
        cmd(0, 0, E("n/in1_d",   0, 1, 0, 1, 0,  1, 0), 0, 1);
        cmd(0, 1, E("n/out_j",   1, 0, 0, 1, 16, 1, 1), 0, 1);
        cmd(1, 0, E("n/inner2",  0, 0, 0, 1, 16, 2, 0), 0, 1);
        cmd(0, 0, E("n/in2_j",   1, 0, 0, 1, 17, 2, 1), 0, 1);
        cmd(0, 0, E("n/in2_d",   0, 1, 0, 1, 16, 1, 1), 0, 1);
        cmd(0, 1, E("n/out_d",   0, 1, 0, 1, 0,  0, 0), 0, 1);

        // Backpressure: response held 5 cycles
        cmd(1, 0, E("bp/start", 0, 0, 0, 0, 0, 1, 0), 0, 1);
        cmd(0, 0, E("bp/end",   1, 0, 0, 0, 2, 1, 1), 5, 1);
        cmd(0, 0, E("bp/exit",  0, 1, 0, 0, 0, 0, 0), 0, 1);

        // Underflow
        cmd(0, 0, E("err/under", 0, 0, 1, 0, 0, 0, 0), 0, 1);

        // Wrap at 2^ADDR_W
        cfg(0, 2, 0, 2);
        cfg(1, 2, 0, 1);
        cfg(2, 0, 0, 18'h3FFFF);
        cmd(1, 2, E("wrap/start", 0, 0, 0, 0, 18'h3FFFF, 1, 0), 0, 1);
        cmd(0, 2, E("wrap/end",   1, 0, 0, 0, 0,         1, 1), 0, 1);
        cmd(0, 2, E("wrap/exit",  0, 1, 0, 0, 18'h3FFFF, 0, 0), 0, 1);

        // Trip 0 exits on first end
        cfg(0, 3, 0, 0);
        cmd(1, 3, E("trip0/start", 0, 0, 0, 0, 18'h3FFFF, 1, 0), 0, 1);
        cmd(0, 3, E("trip0/end",   0, 1, 0, 0, 18'h3FFFF, 0, 0), 0, 1);

        // Negative stride on ch2
        cfg(0, 4, 0, 3);
        cfg(1, 4, 2, 18'h3FFFC);
        cfg(2, 0, 2, 10);
        cmd(1, 4, E("neg/start", 0, 0, 0, 2, 10, 1, 0), 0, 1);
        cmd(0, 4, E("neg/j1",    1, 0, 0, 2, 6,  1, 1), 0, 1);
        cmd(0, 4, E("neg/j2",    1, 0, 0, 2, 2,  1, 2), 0, 1);
        cmd(0, 4, E("neg/exit",  0, 1, 0, 2, 10, 0, 0), 0, 1);

        // Config writes while a loop is active are dropped
        cfg(2, 0, 3, 7);
        cmd(1, 0, E("drop/start", 0, 0, 0, 3, 7, 1, 0), 0, 1);
        cfg(2, 0, 3, 99);
        cfg(0, 0, 0, 5);
        chk("drop/base_live", ch_addr(3), 32'd7);
        cmd(0, 0, E("drop/j",    1, 0, 0, 3, 7, 1, 1), 0, 1);
        cmd(0, 0, E("drop/exit", 0, 1, 0, 3, 7, 0, 0), 0, 1);
        chk("drop/base_after", ch_addr(3), 32'd7);

        // Overflow, leaving the error response pending
        cfg(2, 0, 0, 5);
        for (int i = 0; i < LOOP_DEPTH; i++)
            cmd(1, 0, E($sformatf("ovf/push%0d", i), 0, 0, 0, 0, 5, i + 1, 0), 0, 1);
        cmd(1, 0, E("ovf/ninth", 0, 0, 1, 0, 5, LOOP_DEPTH, 0), 0, 0);

        // Reset while the response is pending
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rmid/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rmid/depth",     32'(bus.depth),     32'd0);
        chk("rmid/addr0",     ch_addr(0),         32'd0);
        chk("rmid/addr3",     ch_addr(3),         32'd0);
        chk("rmid/cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rmid/ready_after", 32'(bus.cmd_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/loop_address_unit.md
Name: loop_address_unit

Overview:
- Parametrised hardware loop-nest sequencer and address generator for the control unit.
- Keeps a loop stack of up to LOOP_DEPTH levels and NUM_CHAN independent address channels (cache and main memory address per APU).
- Addresses are updated incrementally: the stride of the innermost loop is added on each back-edge, and each channel's address is restored from a saved copy when its loop exits. No multipliers are used.
- Commands arrive from the decode FSM through a valid/ready handshake. Each command produces one response (jump, done or error) through a second valid/ready handshake.

Parameters:
LOOP_DEPTH, 8, maximum nesting depth of the loop stack
LOOP_SLOTS, 8, number of programmable loop descriptors (loop_address space)
NUM_CHAN, 4, number of address channels
ADDR_W, 18, address width per channel; all arithmetic is modulo 2^ADDR_W
CNT_W, 16, loop counter / trip-count width (CNT_W <= ADDR_W)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-low
cfg_we  in  1  configuration write strobe
cfg_kind  in  2  0=trip count, 1=stride, 2=base address, 3=reserved (ignored)
cfg_slot  in  $clog2(LOOP_SLOTS)  descriptor index (trip/stride)
cfg_chan  in  $clog2(NUM_CHAN)  channel index (stride/base)
cfg_data  in  ADDR_W  data; trip count uses [CNT_W-1:0]
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high together with cmd_valid
cmd_is_start  in  1  1=start_loop, 0=end_loop
cmd_slot  in  $clog2(LOOP_SLOTS)  descriptor used by start_loop
rsp_valid  out  1  response pending
rsp_ready  in  1  response consumed
rsp_jump  out  1  end_loop taken back-edge
rsp_done  out  1  end_loop exited loop
rsp_error  out  1  stack overflow/underflow; command had no effect
addr  out  NUM_CHAN*ADDR_W  channel c at [c*ADDR_W +: ADDR_W]
depth  out  $clog2(LOOP_DEPTH+1)  current stack occupancy
loop_var  out  CNT_W  counter of innermost active loop (0 if depth==0)

Behaviour:
- Reset (reset==0 at posedge): FSM=IDLE; stack empty; every output 0 except cmd_ready=0 during reset; all trip/stride/base tables and addr cleared to 0. A reset asserted mid-command or mid-response aborts it; rsp_valid is 0 on the next cycle.
- FSM states: IDLE and RESP.
  - cmd_ready = (state==IDLE) while reset is high.
  - A fire (cmd_valid && cmd_ready) moves IDLE->RESP.
  - At that same edge the state update, addr, depth, loop_var and the rsp_* flags all become visible, so the response has 1-cycle latency.
  - RESP holds rsp_* stable until rsp_ready==1, then returns to IDLE.
  - Maximum throughput is one command per 2 cycles.
- start_loop:
  - If depth==LOOP_DEPTH: rsp_error=1 and nothing else changes.
  - Otherwise push {slot, count=0, saved_addr[c]=addr[c] for all c} and increment depth.
  - addr is unchanged. loop_var=0. rsp_jump=rsp_done=0.
- end_loop, applied to the top entry:
  - If depth==0: rsp_error=1 and nothing else changes.
  - trip_eff = trip[slot], with 0 treated as 1.
  - If count+1 < trip_eff: count++; addr[c] += stride[slot][c] for every c in parallel, modulo 2^ADDR_W, wrap silently; rsp_jump=1.
  - Otherwise: addr[c] = saved_addr[c]; pop; depth--; rsp_done=1; loop_var shows the new top's count (0 if the stack is now empty).
- Strides are two's-complement, so a negative stride is legal.
- Configuration:
  - Writes take effect at the posedge where cfg_we==1, but only if depth==0, state==IDLE and no command fires that cycle. Otherwise the write is silently dropped.
  - base writes load addr[cfg_chan] directly.
  - Tables are read at command fire, so descriptors stay constant while in use.
- rsp_jump, rsp_done and rsp_error are mutually exclusive and are 0 whenever rsp_valid==0.

Test Plan:
- Single loop: slot0 trip=3, stride[0][0]=2, base ch0=0; send start, end, end, end -> responses none, jump, jump, done; ch0 addr 0,2,4 then restored to 0; depth 1,1,1,0; loop_var 0,1,2,0.
- Nested: outer slot1 trip=2 stride ch1=16; inner slot0 trip=2 stride ch1=1; drive the full nest -> ch1 sequence 0,1,16,17; final exit restores ch1 to 0 with done; depth returns to 0.
- Backpressure: hold rsp_ready=0 for 5 cycles after an end -> rsp_valid and flags stable for 5 cycles, cmd_ready=0 throughout; handshake completes on the cycle after rsp_ready rises.
- Errors: end with depth=0 -> rsp_error=1, addr unchanged. Push 8 starts then a 9th -> rsp_error=1, depth stays 8.
- Boundaries:
  - base=2^18-1, stride=1, trip=2: after one end, ch0=0 (wrap).
  - trip=0: first end gives done immediately.
  - A cfg write during depth>0 is dropped; a base re-read after exit shows the old value.
- Reset mid-RESP: pulse reset low for 1 cycle with rsp_valid=1 -> next cycle rsp_valid=0, depth=0, addr=0, and cmd_ready=1 after reset releases.
